inst_mem_arbiter: RTL

//  Shares one single-port synchronous instruction memory between the IF stage fetch port and a debug/loader port.

---
 rtl/inst_mem_arbiter_if.sv | 54 +++++
 rtl/inst_mem_arbiter.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/inst_mem_arbiter_if.sv
// Bus bundle for inst_mem_arbiter.
// Groups the IF fetch port, the debug/loader port and the memory port.
// Modports:
//   slave  - the arbiter: takes both requester ports, drives grants, responses and the memory bus
//   master - the environment: drives requests and memory read data, observes everything else
interface inst_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  // IF fetch port
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic [DATA_W-1:0] if_inst;
  logic              if_valid;
  logic              stallreq_if;

  // Debug / loader port
  logic              dbg_req;
  logic              dbg_we;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_wdata;
  logic              dbg_lock;
  logic              dbg_gnt;
  logic [DATA_W-1:0] dbg_rdata;
  logic              dbg_valid;

  // Single-port synchronous memory
  logic              mem_ce;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_inst, if_valid, stallreq_if,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
    output dbg_gnt, dbg_rdata, dbg_valid,
    output mem_ce, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_inst, if_valid, stallreq_if,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_lock,
    input  dbg_gnt, dbg_rdata, dbg_valid,
    input  mem_ce, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/inst_mem_arbiter.sv
// Instruction memory arbiter.
// Shares one single-port synchronous instruction memory between the IF fetch port and a
// debug/loader port. One access is granted per cycle; read data returns one cycle later and is
// steered to the port that issued the read. stallreq_if tells the pipeline control that IF is
// waiting this cycle.
//
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous reset, active high
//   bus  - inst_mem_arbiter_if.slave: IF port, debug port and memory port
//
// Build option:
//   INST_ARB_RR_EN defined   - conflicts resolved round-robin
//   INST_ARB_RR_EN undefined - debug has priority, IF forced through after MAX_WAIT denials
module inst_mem_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  inst_mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {OwnNone, OwnIf, OwnDbg} owner_e;
  typedef enum logic {StIdle, StLocked} lock_state_e;

  lock_state_e lock_q, lock_d;
  owner_e      owner_q, owner_d;
  logic [DATA_W-1:0] if_inst_q, if_inst_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;

  logic locked;
  logic if_cand, dbg_cand, contested, if_wins;
  logic if_gnt, dbg_gnt;
  logic if_valid, dbg_valid;
  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] wdata_sel;

`ifdef INST_ARB_RR_EN
  // 0: IF owns the next conflict, 1: debug owns it
  logic rr_q, rr_d;
`else
  localparam logic [3:0] WaitMax = 4'(MAX_WAIT);
  logic [3:0] wait_q, wait_d;
`endif

  // Lock FSM. The lock applies from the cycle dbg_lock is raised and is released in the cycle
  // it drops, so the gate uses the next state rather than the registered one.
  always_comb begin
    lock_d = lock_q;
    unique case (lock_q)
      StIdle:   if (bus.dbg_lock)  lock_d = StLocked;
      StLocked: if (!bus.dbg_lock) lock_d = StIdle;
      default:  lock_d = StIdle;
    endcase
  end

  assign locked = (lock_d == StLocked);

  // Grant selection
  always_comb begin
    if_cand   = bus.if_req & ~locked & ~rst;
    dbg_cand  = bus.dbg_req & ~rst;
    contested = if_cand & dbg_cand;
`ifdef INST_ARB_RR_EN
    if_wins   = ~rr_q;
`else
    if_wins   = (wait_q == WaitMax);
`endif
    if_gnt    = if_cand & (~dbg_cand | if_wins);
    dbg_gnt   = dbg_cand & ~if_gnt;
  end

  // Arbitration state next-values
`ifdef INST_ARB_RR_EN
  always_comb begin
    rr_d = rr_q;
    if (contested) rr_d = ~rr_q;
  end
`else
  // Counts IF denials outside lock; saturates so IF keeps its forced win until granted.
  always_comb begin
    wait_d = wait_q;
    if (if_gnt) begin
      wait_d = '0;
    end else if (bus.if_req && !locked && (wait_q != WaitMax)) begin
      wait_d = wait_q + 4'd1;
    end
  end
`endif

  // Memory port driven from the winner in the same cycle
  always_comb begin
    addr_sel  = '0;
    wdata_sel = '0;
    if (if_gnt) begin
      addr_sel = bus.if_addr;
    end else if (dbg_gnt) begin
      addr_sel = bus.dbg_addr;
      if (bus.dbg_we) wdata_sel = bus.dbg_wdata;
    end
  end

  // Response routing: only reads create a pending response
  always_comb begin
    owner_d = OwnNone;
    if (if_gnt) begin
      owner_d = OwnIf;
    end else if (dbg_gnt && !bus.dbg_we) begin
      owner_d = OwnDbg;
    end
  end

  always_comb begin
    if_valid    = ~rst & (owner_q == OwnIf);
    dbg_valid   = ~rst & (owner_q == OwnDbg);
    if_inst_d   = if_valid  ? bus.mem_rdata : if_inst_q;
    dbg_rdata_d = dbg_valid ? bus.mem_rdata : dbg_rdata_q;
  end

  // Outputs; everything reads as zero while rst is high
  always_comb begin
    bus.if_gnt      = if_gnt;
    bus.dbg_gnt     = dbg_gnt;
    bus.stallreq_if = bus.if_req & ~if_gnt & ~rst;
    bus.mem_ce      = if_gnt | dbg_gnt;
    bus.mem_we      = dbg_gnt & bus.dbg_we;
    bus.mem_addr    = addr_sel;
    bus.mem_wdata   = wdata_sel;
    bus.if_valid    = if_valid;
    bus.dbg_valid   = dbg_valid;
    bus.if_inst     = rst ? '0 : if_inst_d;
    bus.dbg_rdata   = rst ? '0 : dbg_rdata_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q      <= StIdle;
      owner_q     <= OwnNone;
      if_inst_q   <= '0;
      dbg_rdata_q <= '0;
`ifdef INST_ARB_RR_EN
      rr_q        <= 1'b0;
`else
      wait_q      <= '0;
`endif
    end else begin
      lock_q      <= lock_d;
      owner_q     <= owner_d;
      if_inst_q   <= if_inst_d;
      dbg_rdata_q <= dbg_rdata_d;
`ifdef INST_ARB_RR_EN
      rr_q        <= rr_d;
`else
      wait_q      <= wait_d;
`endif
    end
  end

endmodule
